// File: rtl/ram_sdp_pkg.sv
// Shared sizing defaults and word/address types for the 512x32 simple dual-port RAM.
package ram_sdp_pkg;

  localparam int unsigned DATA_WIDTH_DEF = 32;
  localparam int unsigned ADDR_WIDTH_DEF = 9;
  localparam int unsigned DEPTH_DEF      = 512;

  typedef logic [ADDR_WIDTH_DEF-1:0] addr_t;
  typedef logic [DATA_WIDTH_DEF-1:0] data_t;

endpackage

// File: rtl/ram_sdp_array.sv
// Inference-friendly storage: synchronous write port, asynchronous read port.
module ram_sdp_array
  import ram_sdp_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int unsigned ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int unsigned DEPTH      = DEPTH_DEF
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  // Zero at configuration time only; nothing in the design ever clears it.
  logic [DATA_WIDTH-1:0] r_mem [DEPTH] = '{default: '0};

  always_ff @(posedge clk) begin
    if (we) begin
      r_mem[waddr] <= wdata;
    end
  end

  assign rdata = r_mem[raddr];

endmodule

// File: rtl/ram_sdp_reg_addr_512x32.sv
// Simple dual-port RAM with registered read address; reset clears only the read-address register.
module ram_sdp_reg_addr_512x32
  import ram_sdp_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int unsigned ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int unsigned DEPTH      = DEPTH_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] write_addr,
  input  logic [DATA_WIDTH-1:0] din,
  input  logic [ADDR_WIDTH-1:0] read_addr,
  output logic [DATA_WIDTH-1:0] dout
);

  if (DEPTH != (1 << ADDR_WIDTH)) begin : g_depth_check
    $error("DEPTH must equal 2**ADDR_WIDTH");
  end

  logic [ADDR_WIDTH-1:0] r_read_addr_q;
  logic                  w_we;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_read_addr_q <= '0;
    end else begin
      r_read_addr_q <= read_addr;
    end
  end

  // Writes are dropped while reset is asserted.
  assign w_we = we & rst_n;

  ram_sdp_array #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH),
    .DEPTH      (DEPTH)
  ) u_array (
    .clk   (clk),
    .we    (w_we),
    .waddr (write_addr),
    .wdata (din),
    .raddr (r_read_addr_q),
    .rdata (dout)
  );

  a_no_x_ctrl: assert property (@(posedge clk)
    rst_n |-> !$isunknown({we, write_addr, read_addr}))
    else $error("X on we/write_addr/read_addr outside reset");

endmodule

// File: tb/tb_ram_sdp_reg_addr_512x32.sv
// Directed bench for ram_sdp_reg_addr_512x32 with a word-level reference memory.
module tb_ram_sdp_reg_addr_512x32;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        we;
  logic [8:0]  write_addr;
  logic [31:0] din;
  logic [8:0]  read_addr;
  logic [31:0] dout;

  logic [31:0] exp_mem [512];
  logic [8:0]  exp_raddr;
  int unsigned checks   = 0;
  int unsigned failures = 0;

  ram_sdp_reg_addr_512x32 #(
    .DATA_WIDTH (32),
    .ADDR_WIDTH (9),
    .DEPTH      (512)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .we         (we),
    .write_addr (write_addr),
    .din        (din),
    .read_addr  (read_addr),
    .dout       (dout)
  );

  always #5 clk = ~clk;

  // Update the reference for the coming edge, then advance to the next falling edge.
  task automatic tick();
    if (rst_n && we) exp_mem[write_addr] = din;
    exp_raddr = rst_n ? read_addr : 9'd0;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; read_addr = 9'd100; we = 1'b1; write_addr = 9'd0; din = 32'hFFFF_FFFF;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (dout !== 32'h0) begin
        failures++;
        $display("FAIL reset_hold cycle %0d: dout=%h expected=%h", i, dout, 32'h0);
      end
    end
    rst_n = 1'b1; we = 1'b0;
    tick();
    checks++;
    if (dout !== 32'h0) begin
      failures++;
      $display("FAIL reset_release: dout=%h expected mem[100]=%h", dout, 32'h0);
    end
  endtask

  task automatic test_fill();
    we = 1'b1;
    for (int i = 0; i < 512; i++) begin
      write_addr = 9'(i); din = 32'(i);
      tick();
    end
    we = 1'b0;
    for (int i = 0; i < 512; i++) begin
      read_addr = 9'(i);
      tick();
      checks++;
      if (dout !== 32'(i)) begin
        failures++;
        $display("FAIL fill_readback addr %0d: dout=%h expected=%h", i, dout, 32'(i));
      end
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 512; c++) begin
      read_addr  = 9'($urandom_range(0, 255));
      write_addr = 9'($urandom_range(256, 511));
      din        = 32'(c);
      we         = 1'b1;
      tick();
      checks++;
      if (dout !== exp_mem[exp_raddr] || dout !== 32'(exp_raddr)) begin
        failures++;
        $display("FAIL random cycle %0d addr %0d: dout=%h expected=%h", c, exp_raddr, dout,
                 exp_mem[exp_raddr]);
      end
    end
    we = 1'b0;
  endtask

  task automatic test_collision();
    we = 1'b0; read_addr = 9'd300;
    tick();
    checks++;
    if (dout !== exp_mem[300]) begin
      failures++;
      $display("FAIL collision_pre: dout=%h expected=%h", dout, exp_mem[300]);
    end
    we = 1'b1; write_addr = 9'd300; din = 32'h25;
    tick();
    we = 1'b0;
    checks++;
    if (dout !== 32'h25) begin
      failures++;
      $display("FAIL collision: dout=%h expected=%h", dout, 32'h25);
    end
  endtask

  task automatic test_same_edge();
    read_addr = 9'd7; write_addr = 9'd7; din = 32'hA5A5_5A5A; we = 1'b1;
    tick();
    we = 1'b0;
    checks++;
    if (dout !== 32'hA5A5_5A5A) begin
      failures++;
      $display("FAIL same_edge: dout=%h expected=%h", dout, 32'hA5A5_5A5A);
    end
  endtask

  task automatic test_mid_reset();
    read_addr = 9'd300;
    tick();
    we = 1'b1;
    for (int k = 0; k < 8; k++) begin
      write_addr = 9'(20 + k); din = 32'h1000 + 32'(k);
      rst_n = (k != 4);
      tick();
      if (k == 4) begin
        checks++;
        if (dout !== 32'h0) begin
          failures++;
          $display("FAIL mid_reset_dout: dout=%h expected mem[0]=%h", dout, 32'h0);
        end
      end
    end
    rst_n = 1'b1; we = 1'b0;
    for (int k = 0; k < 8; k++) begin
      read_addr = 9'(20 + k);
      tick();
      checks++;
      if (dout !== ((k == 4) ? 32'd24 : 32'h1000 + 32'(k))) begin
        failures++;
        $display("FAIL mid_reset_readback addr %0d: dout=%h expected=%h", 20 + k, dout,
                 (k == 4) ? 32'd24 : 32'h1000 + 32'(k));
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 512; i++) exp_mem[i] = '0;
    exp_raddr = '0;
    rst_n = 1'b0; we = 1'b0; write_addr = '0; din = '0; read_addr = '0;
    @(negedge clk);
    test_reset();
    test_fill();
    test_random();
    test_collision();
    test_same_edge();
    test_mid_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ram_sdp_reg_addr_512x32.md
Name: ram_sdp_reg_addr_512x32

Overview:
- Simple dual-port RAM, 512 words x 32 bits, with one write port and one read port.
- The read address is registered, and the read data comes from a combinational lookup of that registered address.
- Used as a generic on-chip buffer, for example for BRAM inference in FPGA flows.
- Single clock domain. A synchronous active-low reset clears only the read-address register, never the array.

Parameters:
- DATA_WIDTH, 32, width of din/dout.
- ADDR_WIDTH, 9, width of read_addr/write_addr.
- DEPTH, 512, number of words; must equal 2**ADDR_WIDTH.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  synchronous, active-low reset.
- we  input  1  write enable.
- write_addr  input  ADDR_WIDTH  write address.
- din  input  DATA_WIDTH  write data.
- read_addr  input  ADDR_WIDTH  read address, captured every cycle.
- dout  output  DATA_WIDTH  read data, equal to mem[read_addr_q].

Interface rule (already decided): one clock; reset is synchronous and active-low.

Behaviour:
- Storage: mem[0..DEPTH-1] of DATA_WIDTH bits.
  - Initialised to all zeros at configuration / time 0.
  - Never cleared by reset.
- Read-address register read_addr_q:
  - When rst_n=0 at a rising edge of clk, read_addr_q <= 0.
  - Otherwise read_addr_q <= read_addr, every cycle, unconditionally (no read enable).
- Read path: dout = mem[read_addr_q], combinational from the register and array.
  - Latency: a new read_addr appears on dout one clk edge later.
- Reset value of dout: mem[0]. This is 0 after power-up, or whatever was last written to address 0.
- Write:
  - When rst_n=1 and we=1 at a rising edge of clk, mem[write_addr] <= din.
  - Writes are ignored while rst_n=0.
- Collision (write_addr == read_addr_q during a write): dout shows the new din immediately after that edge (write-then-read behaviour). The old value is never held.
- Simultaneous write and read-address update at the same edge, where the new read_addr equals write_addr: after the edge, dout = the newly written din.
- Address range: full 9-bit range valid, no wrap or overflow logic. The whole address width indexes the array.
- X handling: an unknown address or we must not corrupt other words in simulation. Assertions flag X on we/addresses when rst_n=1.
- No handshake, no stall, no error outputs.

Decomposition:
- Package ram_sdp_pkg holds:
  - localparams DATA_WIDTH_DEF=32, ADDR_WIDTH_DEF=9, DEPTH_DEF=512;
  - typedefs addr_t (logic [ADDR_WIDTH-1:0]) and data_t (logic [DATA_WIDTH-1:0]).
- One sub-module is natural: ram_sdp_array.
  - Contains the inference-friendly storage with a synchronous write port and an asynchronous read port.
  - Driven by the top, which owns read_addr_q, reset logic and assertions.

Test Plan:
- Reset check: hold rst_n=0 for 3 cycles with read_addr=100 and we=1, write_addr=0, din=32'hFFFF_FFFF, then release.
  - During and after reset: dout == 0 (mem[0] is unwritten, since writes are ignored in reset).
  - One cycle after release: dout == mem[100] == 0.
- Fill and readback:
  - Write din=i to write_addr=i for i=0..511 (we=1).
  - Then set we=0 and read_addr=i. One cycle later dout == i for every i; covers address 0 and 511.
- Random read/write: over 512 cycles, set read_addr random in 0..255, write_addr random in 256..511, din = cycle index.
  - dout always equals a reference model; reads of the lower half return values from the fill phase.
- Collision:
  - Set read_addr=300 and let it register.
  - Then write_addr=300, din=32'h25, we=1. After that edge dout == 32'h25 without changing read_addr.
- Same-edge case: read_addr=7 and write_addr=7 presented together with din=32'hA5A5_5A5A, we=1.
  - Next cycle dout == 32'hA5A5_5A5A.
- Mid-operation reset: assert rst_n=0 for one cycle during a write burst.
  - The write at that edge is dropped (the target address keeps its old data).
  - read_addr_q goes to 0, so dout == mem[0].
  - Earlier writes are preserved and read back correctly afterwards.
